// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet-locking arbiter for a shared FIFO write port
//
// Shares one FIFO write port among N producers. An idle arbiter picks the first
// requester at or after the round-robin pointer; a multi-beat packet then holds
// the port until its last beat, so packets land in the FIFO contiguously.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req[N]       per-requester beat valid
//   last[N]      per-requester final-beat marker, qualified by req
//   data[N*W]    requester i's beat on [i*W +: W]
//   gnt[N]       one-hot or zero; beat from requester i accepted this cycle
//   fifo_full    FIFO full (registered in the FIFO, so no loop through gnt)
//   fifo_wr_err  FIFO write error, only reaches outputs through err_sticky
//   fifo_we      FIFO write enable
//   fifo_din     FIFO write data, zero when nothing is granted
//   owner        requester holding the lock; keeps its value in IDLE
//   busy         1 while a packet holds the lock
//   err_sticky   FIFO write error seen since the last clear
//   clr_err      synchronous clear of err_sticky (a same-cycle error wins)

module fifo_wr_arbiter #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    last,
   input  logic [N*W-1:0]  data,
   output logic [N-1:0]    gnt,
   input  logic            fifo_full,
   input  logic            fifo_wr_err,
   output logic            fifo_we,
   output logic [W-1:0]    fifo_din,
   output logic [IW-1:0]   owner,
   output logic            busy,
   output logic            err_sticky,
   input  logic            clr_err
);

   typedef enum logic {IDLE, LOCKED} st_t;

   st_t           st, st_n;
   logic [IW-1:0] ptr, ptr_n, owner_n;
   logic [IW-1:0] win, cand, gidx;
   logic          found, vld;

   // Explicit compare against N-1 so non-power-of-two N wraps correctly.
   function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
      return (x == IW'(N - 1)) ? '0 : x + IW'(1);
   endfunction

   // Rotating search starting at ptr.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = ptr;
      for (int k = 0; k < N; k++) begin
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
         cand = inc(cand);
      end
   end

   // Grant selection. Reset is folded in so outputs drop without a clock edge.
   always_comb begin
      vld  = 1'b0;
      gidx = '0;
      if (rst && !fifo_full) begin
         if (st == LOCKED) begin
            vld  = req[owner];
            gidx = owner;
         end else begin
            vld  = found;
            gidx = win;
         end
      end
   end

   always_comb begin
      gnt      = '0;
      fifo_din = '0;
      for (int i = 0; i < N; i++) begin
         if (vld && gidx == IW'(i)) begin
            gnt[i]   = 1'b1;
            fifo_din = data[i*W +: W];
         end
      end
      fifo_we = vld;
   end

   // Next state: only a grant moves the FSM; bubbles and full stalls hold everything.
   always_comb begin
      st_n    = st;
      ptr_n   = ptr;
      owner_n = owner;
      if (vld) begin
         if (st == IDLE) begin
            if (last[gidx]) begin
               ptr_n = inc(gidx);
            end else begin
               st_n    = LOCKED;
               owner_n = gidx;
            end
         end else if (last[gidx]) begin
            st_n  = IDLE;
            ptr_n = inc(owner);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st    <= IDLE;
         ptr   <= '0;
         owner <= '0;
      end else begin
         st    <= st_n;
         ptr   <= ptr_n;
         owner <= owner_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_sticky <= 1'b0;
      else if (fifo_wr_err)
         err_sticky <= 1'b1;
      else if (clr_err)
         err_sticky <= 1'b0;
   end

   assign busy = (st == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int IW = 2;
   localparam int DEPTH = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    last;
   logic [N*W-1:0]  data;
   logic [N-1:0]    gnt;
   logic            fifo_full;
   logic            fifo_wr_err;
   logic            fifo_we;
   logic [W-1:0]    fifo_din;
   logic [IW-1:0]   owner;
   logic            busy;
   logic            err_sticky;
   logic            clr_err;

   int checks = 0;
   int failures = 0;

   // reference model state
   int   m_ptr = 0;
   int   m_owner = 0;
   bit   m_locked = 0;
   bit   m_err = 0;
   // FIFO environment
   int   occ = 0;
   int   overflow = 0;
   logic [W-1:0] act_log[$];
   logic [W-1:0] exp_log[$];

   fifo_wr_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .gnt(gnt),
      .fifo_full(fifo_full), .fifo_wr_err(fifo_wr_err), .fifo_we(fifo_we),
      .fifo_din(fifo_din), .owner(owner), .busy(busy), .err_sticky(err_sticky),
      .clr_err(clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Winner by the arbitration rules: -1 when nothing may be accepted.
   function automatic int mgrant();
      if (!rst || fifo_full) return -1;
      if (m_locked) return req[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++)
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] mgnt();
      logic [N-1:0] v;
      int g;
      v = '0;
      g = mgrant();
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic logic [W-1:0] mdin();
      int g;
      g = mgrant();
      return (g >= 0) ? data[g*W +: W] : '0;
   endfunction

   // Advances one clock: logs writes, steps the model and the FIFO occupancy.
   task automatic tick(input bit rd);
      int g;
      bit push, pop;
      g = mgrant();
      push = fifo_we;
      if (fifo_we) begin
         act_log.push_back(fifo_din);
         if (fifo_full) overflow++;
      end
      if (g >= 0) begin
         exp_log.push_back(data[g*W +: W]);
         if (!m_locked) begin
            if (last[g]) m_ptr = (g + 1) % N;
            else begin m_locked = 1; m_owner = g; end
         end else if (last[g]) begin
            m_locked = 0;
            m_ptr = (m_owner + 1) % N;
         end
      end
      if (fifo_wr_err) m_err = 1;
      else if (clr_err) m_err = 0;
      pop = rd && (occ > 0);
      @(posedge clk);
      #1;
      occ = occ + int'(push) - int'(pop);
      fifo_full = (occ >= DEPTH);
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '1; last = '1; data = {$urandom};
      fifo_full = 1'b0; fifo_wr_err = 1'b0; clr_err = 1'b0;
      #12;
      checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
      checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", fifo_we); end
      checks++; if (fifo_din !== '0) begin failures++; $display("FAIL reset_din got=%h exp=0", fifo_din); end
      checks++; if (busy !== 1'b0 || owner !== '0 || err_sticky !== 1'b0) begin
         failures++; $display("FAIL reset_state got busy=%b owner=%0d err=%b exp 0/0/0", busy, owner, err_sticky); end
      req = '0; last = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_round_robin();
      req = '1; last = '1;
      for (int c = 0; c < 5; c++) begin
         logic [N-1:0] eg;
         data = {$urandom};
         eg = '0; eg[c % N] = 1'b1;
         #1;
         checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
         checks++; if (fifo_din !== data[(c % N)*W +: W]) begin
            failures++; $display("FAIL rr_din cyc=%0d got=%h exp=%h", c, fifo_din, data[(c % N)*W +: W]); end
         tick(1);
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_busy cyc=%0d got=%b exp=0", c, busy); end
      end
      req = '0;
   endtask

   task automatic test_packet();
      logic [W-1:0] a[3];
      logic [W-1:0] r0;
      logic [W-1:0] want[4];
      act_log.delete(); exp_log.delete();
      r0 = W'($urandom);
      for (int b = 0; b < 3; b++) a[b] = W'($urandom);
      for (int b = 0; b < 3; b++) begin
         req = 4'b0101; last = (b == 2) ? 4'b0101 : 4'b0001;
         data = '0; data[0 +: W] = r0; data[2*W +: W] = a[b];
         #1;
         checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL pkt_gnt beat=%0d got=%b exp=0100", b, gnt); end
         tick(1);
         if (b < 2) begin
            checks++; if (busy !== 1'b1 || owner !== 2'd2) begin
               failures++; $display("FAIL pkt_lock beat=%0d got busy=%b owner=%0d exp 1/2", b, busy, owner); end
         end
      end
      req = 4'b0001; last = 4'b0001;
      #1;
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL pkt_after got=%b exp=0001", gnt); end
      tick(1);
      req = '0; last = '0;
      want[0] = a[0]; want[1] = a[1]; want[2] = a[2]; want[3] = r0;
      checks++; if (act_log.size() != 4) begin failures++; $display("FAIL pkt_count got=%0d exp=4", act_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (act_log[i] !== want[i]) begin failures++; $display("FAIL pkt_order idx=%0d got=%h exp=%h", i, act_log[i], want[i]); end
      end
   endtask

   task automatic test_owner_bubble();
      data = {$urandom};
      req = 4'b0010; last = 4'b0000;
      #1;
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bub_first got=%b exp=0010", gnt); end
      tick(1);
      checks++; if (busy !== 1'b1 || owner !== 2'd1) begin failures++; $display("FAIL bub_lock got busy=%b owner=%0d exp 1/1", busy, owner); end
      for (int c = 0; c < 2; c++) begin
         req = 4'b1000; last = 4'b1000;
         #1;
         checks++; if (gnt !== '0 || fifo_we !== 1'b0) begin
            failures++; $display("FAIL bub_hold cyc=%0d got gnt=%b we=%b exp 0000/0", c, gnt, fifo_we); end
         tick(1);
      end
      req = 4'b1010; last = 4'b1000;
      #1;
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bub_mid got=%b exp=0010", gnt); end
      tick(1);
      last = 4'b1010;
      #1;
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bub_last got=%b exp=0010", gnt); end
      tick(1);
      req = 4'b1000;
      #1;
      checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL bub_r3 got=%b exp=1000", gnt); end
      tick(1);
      req = '0; last = '0;
   endtask

   task automatic test_full_stall();
      int n, acc;
      occ = 0; fifo_full = 1'b0; overflow = 0;
      req = '1; last = '1; data = {$urandom};
      n = 0;
      while (!fifo_full && n < 10) begin tick(0); n++; end
      checks++; if (!fifo_full || n != DEPTH) begin failures++; $display("FAIL full_fill got=%0d beats exp=%0d", n, DEPTH); end
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (gnt !== '0 || fifo_we !== 1'b0) begin
            failures++; $display("FAIL full_stall cyc=%0d got gnt=%b we=%b exp 0000/0", c, gnt, fifo_we); end
         tick(0);
      end
      tick(1);
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (fifo_we) acc++;
         tick(0);
      end
      checks++; if (acc != 1) begin failures++; $display("FAIL full_one got=%0d exp=1", acc); end
      checks++; if (overflow != 0 || err_sticky !== 1'b0) begin
         failures++; $display("FAIL full_wr_err got ovf=%0d err=%b exp 0/0", overflow, err_sticky); end
      req = '0; last = '0; occ = 0; fifo_full = 1'b0;
   endtask

   task automatic test_err_flag();
      fifo_wr_err = 1'b1;
      #1;
      checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_comb got=%b exp=0", err_sticky); end
      tick(1);
      fifo_wr_err = 1'b0;
      checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_sticky); end
      tick(1);
      checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err_sticky); end
      fifo_wr_err = 1'b1; clr_err = 1'b1;
      tick(1);
      fifo_wr_err = 1'b0;
      checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_setwins got=%b exp=1", err_sticky); end
      tick(1);
      clr_err = 1'b0;
      checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err_sticky); end
   endtask

   task automatic test_mid_reset();
      data = {$urandom};
      req = 4'b0010; last = 4'b0010;
      tick(1);
      req = 4'b1000; last = 4'b0000;
      tick(1);
      checks++; if (busy !== 1'b1 || owner !== 2'd3) begin failures++; $display("FAIL mrst_lock got busy=%b owner=%0d exp 1/3", busy, owner); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || gnt !== '0 || fifo_we !== 1'b0) begin
         failures++; $display("FAIL mrst_async got busy=%b gnt=%b we=%b exp 0/0000/0", busy, gnt, fifo_we); end
      m_ptr = 0; m_owner = 0; m_locked = 0; m_err = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      req = 4'b1110; last = 4'b1110;
      #1;
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mrst_search got=%b exp=0010", gnt); end
      tick(1);
      req = '0; last = '0;
   endtask

   task automatic test_random();
      act_log.delete(); exp_log.delete();
      occ = 0; fifo_full = 1'b0; overflow = 0;
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] eg;
         logic [W-1:0] ed;
         req = N'($urandom); last = N'($urandom); data = {$urandom};
         #1;
         eg = mgnt(); ed = mdin();
         checks++; if (gnt !== eg || fifo_we !== (eg != '0)) begin
            failures++; $display("FAIL rnd_gnt cyc=%0d got=%b/%b exp=%b", c, gnt, fifo_we, eg); end
         checks++; if (fifo_din !== ed) begin failures++; $display("FAIL rnd_din cyc=%0d got=%h exp=%h", c, fifo_din, ed); end
         tick($urandom_range(0, 1) == 1);
         checks++; if (busy !== m_locked || (m_locked && owner !== IW'(m_owner))) begin
            failures++; $display("FAIL rnd_state cyc=%0d got busy=%b owner=%0d exp %0d/%0d", c, busy, owner, m_locked, m_owner); end
      end
      req = '0; last = '0;
      checks++; if (act_log != exp_log) begin failures++; $display("FAIL rnd_log got=%0d beats exp=%0d", act_log.size(), exp_log.size()); end
      checks++; if (overflow != 0) begin failures++; $display("FAIL rnd_overflow got=%0d exp=0", overflow); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_packet();
      test_owner_bubble();
      test_full_stall();
      test_err_flag();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares a single `sync_FIFO` write port among N producers. Each producer presents beats with a `last` marker. Once a producer wins, it holds the port until its packet's final beat, so packets land in the FIFO contiguously. The block sits between the producer blocks and the FIFO `we`/`din`/`full`/`wr_err` pins. It never writes into a full FIFO, and it latches any FIFO write error into a sticky flag.

## Interface
Parameters:
- `N`, 4: number of requesters; legal range 2..16.
- `W`, 8: data width; matches the FIFO `din` width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low (0 = reset asserted).
- `req`, input, N: per-requester beat valid.
- `last`, input, N: per-requester final-beat-of-packet marker; qualified by `req`.
- `data`, input, N*W: requester i's beat is on bits [i*W +: W].
- `gnt`, output, N: one-hot or zero; the beat from requester i is accepted this cycle.
- `fifo_full`, input, 1: FIFO `full`.
- `fifo_wr_err`, input, 1: FIFO `wr_err`.
- `fifo_we`, output, 1: FIFO write enable.
- `fifo_din`, output, W: FIFO write data.
- `owner`, output, clog2(N): index of the requester currently holding the lock; value is held in IDLE.
- `busy`, output, 1: 1 in state LOCKED.
- `err_sticky`, output, 1: a FIFO write error has been seen since the last clear.
- `clr_err`, input, 1: synchronous clear of `err_sticky`.

## Operation
- State: `st` ∈ {IDLE, LOCKED}, `ptr` (round-robin start index, clog2(N) bits), `owner`, `err_sticky`.
- Reset (`rst`=0, asynchronous):
  - `st`=IDLE, `ptr`=0, `owner`=0, `err_sticky`=0.
  - `gnt`=0, `fifo_we`=0, `fifo_din`=0 (forced while reset is asserted).
- Grant is combinational from the current state and inputs:
  - If `fifo_full`=1, then `gnt`=0 and `fifo_we`=0.
  - IDLE: the winner is the first i with `req[i]`=1, searching `ptr`, `ptr`+1, … mod N.
  - LOCKED: the only candidate is `owner`. Other requesters wait even if `req` is high.
- On a grant to i: `gnt[i]`=1, `fifo_we`=1, `fifo_din`=`data[i*W +: W]`. With no grant, `fifo_din`=0.
- Next-state transitions, applied on the clock edge when a grant to i occurs:
  - IDLE with `last[i]`=1 (single-beat packet): stay IDLE, `ptr`←(i+1) mod N.
  - IDLE with `last[i]`=0: go to LOCKED, `owner`←i.
  - LOCKED with `last[owner]`=1: go to IDLE, `ptr`←(owner+1) mod N.
  - LOCKED with `last`=0: stay LOCKED.
- No grant: state, `ptr` and `owner` are unchanged. This covers:
  - an owner bubble (`req[owner]`=0);
  - a FIFO-full stall.
- Wrap-around: `ptr` and `owner`+1 wrap modulo N. For non-power-of-2 N the increment must compare against N-1 explicitly.
- `err_sticky`:
  - set on any cycle where `fifo_wr_err`=1;
  - cleared when `clr_err`=1;
  - if both occur in the same cycle, set wins.
- `fifo_wr_err` must never be caused by this block. A set `err_sticky` indicates an external writer or integration fault.
- `last` without `req` is ignored. `data` from non-granted requesters is ignored.

## Timing
- Grant latency: zero cycles. A beat is accepted in the same cycle that `req` and `!fifo_full` hold. The FIFO captures it on that rising edge.
- Handshake: a requester holds `req`, `last` and `data` stable until it sees `gnt`. It advances to its next beat on the cycle after `gnt`.
- Throughput: one beat per cycle, back-to-back, including the IDLE→LOCKED→IDLE path. No turnaround bubble between packets from different requesters.
- `busy` and `owner` are registered and reflect state after the edge.
- `fifo_full` is combinational into `gnt` and `fifo_we`. The `full` from `sync_FIFO` is registered, so there is no combinational loop.
- Mid-packet reset: returns to IDLE immediately. The partial packet already in the FIFO is not retracted.
- No combinational path from `clr_err` or `fifo_wr_err` to any output except through the `err_sticky` register.

## Test plan
- Reset, then `req`=4'b1111 with all `last`=1 and the FIFO not full:
  - grants issue in order 0,1,2,3,0 on five consecutive cycles;
  - `fifo_din` matches each requester's data;
  - `busy` stays 0.
- Requester 2 sends a 3-beat packet (A0,A1,A2, `last` on A2) while requester 0 holds `req` throughout:
  - `gnt[2]` for 3 cycles with `busy`=1 and `owner`=2;
  - then `gnt[0]`;
  - FIFO contents are A0,A1,A2,R0 in order.
- Owner bubble: in LOCKED with `owner`=1, drop `req[1]` for 2 cycles while `req[3]`=1:
  - `gnt`=0 and `fifo_we`=0 for those 2 cycles;
  - requester 3 is not granted until requester 1 completes its `last` beat.
- Full stall: fill the FIFO through the arbiter until `fifo_full`=1 with `req` still high:
  - `fifo_we`=0 and `gnt`=0 for as long as full is high;
  - FIFO `wr_err` stays 0;
  - after one FIFO read, exactly one beat is accepted.
- Error flag:
  - force `fifo_wr_err`=1 for one cycle → `err_sticky`=1 and held;
  - `clr_err`=1 in the same cycle as `fifo_wr_err`=1 → stays 1;
  - `clr_err` alone → 0.
- Reset mid-packet: assert `rst`=0 asynchronously while LOCKED with `owner`=3:
  - `busy`, `gnt` and `fifo_we` go to 0 without waiting for a clock edge;
  - after release, the first grant searches from index 0.
